qc_ldpc_syndrome_checker: RTL and testbench



---
 rtl/qc_ldpc_pkg.sv | 45 ++++
 rtl/qc_ldpc_syndrome_checker_if.sv | 29 ++
 rtl/qc_ldpc_syndrome_row.sv | 34 +++
 rtl/qc_ldpc_syndrome_checker.sv | 131 +++++++++++++
 tb/tb_qc_ldpc_syndrome_checker.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/qc_ldpc_pkg.sv
// Shared QC-LDPC definitions: code dimensions, base-matrix shifts, FSM states, circulant helper.
// QC_LDPC_SYNDROME_WEIGHT_EN adds the COUNT state used by the syndrome-weight option.
package qc_ldpc_pkg;

  localparam int Z_DEF  = 88;
  localparam int MB_DEF = 16;
  localparam int NB_DEF = 41;
  localparam int KB_DEF = NB_DEF - MB_DEF;

  // Each entry is an 8-bit two's-complement shift; 8'hFF (-1) marks an all-zero block.
  localparam logic [7:0] ZERO_BLK = 8'hFF;
  typedef logic [MB_DEF-1:0][NB_DEF-1:0][7:0] shift_tbl_t;

  // Info columns are pseudo-random circulants; parity columns form a dual diagonal of
  // identities so the encoder can solve parity row by row.
  function automatic shift_tbl_t gen_base_shift();
    shift_tbl_t t;
    for (int r = 0; r < MB_DEF; r++) begin
      for (int c = 0; c < NB_DEF; c++) begin
        if (c < KB_DEF)
          t[r][c] = ((r + 2 * c) % 5 == 0) ? ZERO_BLK : 8'((r * 37 + c * 53 + r * c * 11) % Z_DEF);
        else
          t[r][c] = (c - KB_DEF == r || c - KB_DEF + 1 == r) ? 8'h00 : ZERO_BLK;
      end
    end
    return t;
  endfunction

  localparam shift_tbl_t BASE_SHIFT = gen_base_shift();

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
`ifdef QC_LDPC_SYNDROME_WEIGHT_EN
    ST_COUNT,
`endif
    ST_FIN
  } state_t;

  // (k - s) mod z for 0 <= k, s < z, without a divider.
  function automatic int mod_sub(input int k, input int s, input int z);
    return (k >= s) ? (k - s) : (k - s + z);
  endfunction

endpackage

// File: rtl/qc_ldpc_syndrome_checker_if.sv
// Frame-input / result bundle of the syndrome checker.
// unsat_count exists only when QC_LDPC_SYNDROME_WEIGHT_EN is defined.
interface qc_ldpc_syndrome_checker_if
  import qc_ldpc_pkg::*;
#(
  parameter int Z  = Z_DEF,
  parameter int MB = MB_DEF
);
  logic          start;
  logic          in_valid;
  logic          in_bit;
  logic          busy;
  logic          done;
  logic          syndrome_zero;
  logic [MB*Z-1:0] syndrome;
`ifdef QC_LDPC_SYNDROME_WEIGHT_EN
  logic [$clog2(MB*Z+1)-1:0] unsat_count;

  modport master (output start, in_valid, in_bit,
                  input  busy, done, syndrome_zero, syndrome, unsat_count);
  modport slave  (input  start, in_valid, in_bit,
                  output busy, done, syndrome_zero, syndrome, unsat_count);
`else
  modport master (output start, in_valid, in_bit,
                  input  busy, done, syndrome_zero, syndrome);
  modport slave  (input  start, in_valid, in_bit,
                  output busy, done, syndrome_zero, syndrome);
`endif
endinterface

// File: rtl/qc_ldpc_syndrome_row.sv
// One Z-bit syndrome block: toggles the check hit by the incoming bit through this row's circulant.
module qc_ldpc_syndrome_row
  import qc_ldpc_pkg::*;
#(
  parameter int Z  = Z_DEF,
  parameter int BW = $clog2(Z)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          accept,
  input  logic [7:0]    shift,
  input  logic [BW-1:0] bit_idx,
  input  logic          in_bit,
  output logic [Z-1:0]  blk,
  output logic [Z-1:0]  blk_nxt
);
  logic [BW-1:0] pos;

  assign pos = BW'(mod_sub(int'(bit_idx), int'(shift), Z));

  always_comb begin
    blk_nxt = blk;
    if (clear)
      blk_nxt = '0;
    else if (accept && in_bit && shift != ZERO_BLK)
      blk_nxt[pos] = ~blk[pos];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) blk <= '0;
    else       blk <= blk_nxt;
  end
endmodule

// File: rtl/qc_ldpc_syndrome_checker.sv
// Serial QC-LDPC syndrome checker: accumulates H*c^T bit by bit and flags valid codewords.
// Defining QC_LDPC_SYNDROME_WEIGHT_EN adds a per-block popcount pass producing unsat_count.
module qc_ldpc_syndrome_checker
  import qc_ldpc_pkg::*;
#(
  parameter int Z  = Z_DEF,
  parameter int MB = MB_DEF,
  parameter int NB = NB_DEF,
  parameter logic [MB-1:0][NB-1:0][7:0] SHIFT_TABLE = BASE_SHIFT
) (
  input logic clk,
  input logic reset,
  qc_ldpc_syndrome_checker_if.slave bus
);
  localparam int BW = $clog2(Z);
  localparam int CW = $clog2(NB);

  state_t          state;
  logic [BW-1:0]   bit_idx;
  logic [CW-1:0]   col_idx;
  logic            busy_r, done_r, zero_r;
  logic            accept;
  logic [Z-1:0]    blk     [MB];
  logic [Z-1:0]    blk_nxt [MB];
  logic [MB*Z-1:0] syn_nxt;

  // start always wins, so a bit presented alongside it is never folded in.
  assign accept = (state == ST_RECV) && bus.in_valid && !bus.start;

  for (genvar r = 0; r < MB; r++) begin : g_row
    qc_ldpc_syndrome_row #(.Z(Z), .BW(BW)) u_row (
      .clk     (clk),
      .reset   (reset),
      .clear   (bus.start),
      .accept  (accept),
      .shift   (SHIFT_TABLE[r][col_idx]),
      .bit_idx (bit_idx),
      .in_bit  (bus.in_bit),
      .blk     (blk[r]),
      .blk_nxt (blk_nxt[r])
    );
    assign bus.syndrome[r*Z +: Z] = blk[r];
    assign syn_nxt[r*Z +: Z]      = blk_nxt[r];
  end

`ifdef QC_LDPC_SYNDROME_WEIGHT_EN
  localparam int RW = (MB > 1) ? $clog2(MB) : 1;
  localparam int UW = $clog2(MB*Z+1);
  logic [RW-1:0] cnt_row;
  logic [UW-1:0] acc, pop, unsat_r;

  assign pop             = UW'($countones(blk[cnt_row]));
  assign bus.unsat_count = unsat_r;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      col_idx <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      zero_r  <= 1'b0;
`ifdef QC_LDPC_SYNDROME_WEIGHT_EN
      cnt_row <= '0;
      acc     <= '0;
      unsat_r <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      if (bus.start) begin
        state   <= ST_RECV;
        bit_idx <= '0;
        col_idx <= '0;
        busy_r  <= 1'b1;
        zero_r  <= 1'b0;
`ifdef QC_LDPC_SYNDROME_WEIGHT_EN
        cnt_row <= '0;
        acc     <= '0;
        unsat_r <= '0;
`endif
      end else begin
        case (state)
          ST_RECV: begin
            if (bus.in_valid) begin
              if (bit_idx == BW'(Z-1)) begin
                bit_idx <= '0;
                if (col_idx == CW'(NB-1)) begin
                  col_idx <= '0;
`ifdef QC_LDPC_SYNDROME_WEIGHT_EN
                  state   <= ST_COUNT;
`else
                  // The last bit lands in the same edge, so judge the post-update syndrome.
                  state   <= ST_FIN;
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  zero_r  <= ~|syn_nxt;
`endif
                end else begin
                  col_idx <= col_idx + 1'b1;
                end
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
`ifdef QC_LDPC_SYNDROME_WEIGHT_EN
          ST_COUNT: begin
            if (cnt_row == RW'(MB-1)) begin
              unsat_r <= acc + pop;
              state   <= ST_FIN;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              zero_r  <= ~|bus.syndrome;
            end else begin
              acc     <= acc + pop;
              cnt_row <= cnt_row + 1'b1;
            end
          end
`endif
          ST_FIN:  state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.syndrome_zero = zero_r;
endmodule

// File: tb/tb_qc_ldpc_syndrome_checker.sv
// Randomized/directed bench for qc_ldpc_syndrome_checker against a matrix-level syndrome model.
module tb_qc_ldpc_syndrome_checker;
  import qc_ldpc_pkg::*;

  localparam int Z  = Z_DEF;
  localparam int MB = MB_DEF;
  localparam int NB = NB_DEF;
  localparam int KB = NB - MB;
  localparam int N  = NB * Z;
  localparam int SW = MB * Z;
`ifdef QC_LDPC_SYNDROME_WEIGHT_EN
  localparam int LAT = MB + 1;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total, bad, done_cnt;

  qc_ldpc_syndrome_checker_if #(.Z(Z), .MB(MB)) bus ();

  qc_ldpc_syndrome_checker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial done_cnt = 0;
  always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  // H has a 1 at (r*Z+i, c*Z+k) exactly when k = (i + shift) mod Z.
  function automatic logic [SW-1:0] model_syn(input logic [N-1:0] f);
    logic [SW-1:0] s;
    int c, k, sh;
    s = '0;
    for (int n = 0; n < N; n++) begin
      if (f[n]) begin
        c = n / Z;
        k = n % Z;
        for (int r = 0; r < MB; r++) begin
          sh = int'($signed(BASE_SHIFT[r][c]));
          if (sh >= 0) s[r*Z + ((k - sh) % Z + Z) % Z] ^= 1'b1;
        end
      end
    end
    return s;
  endfunction

  // Parity blocks solved down the dual diagonal: p0 = lam0, pj = lamj ^ p(j-1).
  function automatic logic [N-1:0] encode(input logic [N-1:0] src);
    logic [N-1:0]  w;
    logic [SW-1:0] lam;
    logic [Z-1:0]  p;
    w = src;
    w[N-1:KB*Z] = '0;
    lam = model_syn(w);
    p = '0;
    for (int j = 0; j < MB; j++) begin
      p = p ^ lam[j*Z +: Z];
      w[(KB+j)*Z +: Z] = p;
    end
    return w;
  endfunction

  function automatic logic [N-1:0] rand_frame();
    logic [N-1:0] f;
    for (int n = 0; n < N; n++) f[n] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic with_valid);
    bus.start    = 1'b1;
    bus.in_valid = with_valid;
    bus.in_bit   = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  // gap_mode: 0 gapless, 1 one idle cycle between bits, 2 random 0..1 idle cycles.
  task automatic send_bits(input logic [N-1:0] f, input int count, input int gap_mode);
    int g;
    for (int n = 0; n < count; n++) begin
      if (n > 0) @(negedge clk);
      g = 0;
      if (gap_mode == 1 && n > 0) g = 1;
      if (gap_mode == 2) g = $urandom_range(0, 1);
      repeat (g) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_bit   = f[n];
    end
  endtask

  task automatic run_frame(input string tag, input logic [N-1:0] f, input int gap_mode,
                           input logic start_with_valid);
    logic [SW-1:0] exp;
    int lat, d0;
    exp = model_syn(f);
    d0  = done_cnt;
    pulse_start(start_with_valid);
    chk({tag, ".busy_run"}, SW'(bus.busy), SW'(1));
    send_bits(f, N, gap_mode);
    lat = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
    end while (bus.done !== 1'b1 && lat < 300);
    chk({tag, ".latency"}, SW'(lat), SW'(LAT));
    chk({tag, ".syndrome"}, bus.syndrome, exp);
    chk({tag, ".zero"}, SW'(bus.syndrome_zero), SW'(exp == '0));
    chk({tag, ".busy_end"}, SW'(bus.busy), SW'(0));
`ifdef QC_LDPC_SYNDROME_WEIGHT_EN
    chk({tag, ".unsat"}, SW'(bus.unsat_count), SW'($countones(exp)));
`endif
    @(negedge clk);
    chk({tag, ".done_pulse"}, SW'(bus.done), SW'(0));
    chk({tag, ".done_cnt"}, SW'(done_cnt), SW'(d0 + 1));
  endtask

  initial begin
    logic [N-1:0]  f, enc, bad_word;
    logic [SW-1:0] held;
    int d0;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.busy", SW'(bus.busy), SW'(0));
    chk("reset.done", SW'(bus.done), SW'(0));
    chk("reset.zero", SW'(bus.syndrome_zero), SW'(0));
    chk("reset.syndrome", bus.syndrome, '0);
    reset = 1'b0;
    @(negedge clk);

    // in_valid in IDLE must be ignored.
    repeat (10) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("idle_ignore", bus.syndrome, '0);

    run_frame("zero", '0, 0, 1'b0);

    f = '0;
    f[0] = 1'b1;
    run_frame("bit0", f, 0, 1'b0);

    enc = encode(rand_frame());
    run_frame("encoded", enc, 0, 1'b0);

    bad_word = enc;
    bad_word[1000] = ~bad_word[1000];
    run_frame("flip1000", bad_word, 0, 1'b0);

    held = bus.syndrome;
    d0   = done_cnt;
    repeat (40) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("post_frame.syndrome", bus.syndrome, held);
    chk("post_frame.busy", SW'(bus.busy), SW'(0));
    chk("post_frame.done_cnt", SW'(done_cnt), SW'(d0));

    run_frame("zero_toggle", '0, 1, 1'b0);
    run_frame("rand_gaps", rand_frame(), 2, 1'b0);
    run_frame("start_with_valid", rand_frame(), 0, 1'b1);

    d0 = done_cnt;
    pulse_start(1'b0);
    send_bits(rand_frame(), 700, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_reset.busy", SW'(bus.busy), SW'(0));
    chk("mid_reset.syndrome", bus.syndrome, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    chk("mid_reset.no_done", SW'(done_cnt), SW'(d0));
    run_frame("after_reset", '0, 0, 1'b0);

    d0  = done_cnt;
    enc = encode(rand_frame());
    bad_word = enc;
    bad_word[37] = ~bad_word[37];
    pulse_start(1'b0);
    send_bits(bad_word, 500, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    run_frame("abort_restart", enc, 0, 1'b0);
    chk("abort.single_done", SW'(done_cnt), SW'(d0 + 1));
    chk("abort.zero", SW'(bus.syndrome_zero), SW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
